// File: rtl/carry_skip_add_arbiter.sv
// carry_skip_add_arbiter: shares one carry-skip adder among NREQ valid/ready
// requesters. A round-robin arbiter grants one request per cycle. The result is
// captured in a one-entry response register that is tagged with the requester
// ID. A requester can lock the adder for multi-word additions. While the adder
// is locked, the stored carry-out feeds the cin of the next beat.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is combinational)
//   req_a/req_b          packed operands, requester i at [i*N +: N]
//   req_cin/req_chain    per-requester carry-in / continue-into-next-beat
//   rsp_valid/rsp_ready  response handshake
//   rsp_id/rsp_sum/rsp_cout  registered result and its requester ID

// Carry-skip adder: ripple inside each block, bypass the block carry when every
// bit of the block propagates. A narrower last block absorbs any remainder.
module carry_skip_adder #(
    parameter int unsigned N          = 8,
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    localparam int unsigned BS = (BLOCK_SIZE == 0) ? 1 : BLOCK_SIZE;

    logic c;
    logic blk_cin;
    logic blk_p;
    logic p;

    always_comb begin
        sum     = '0;
        c       = cin;
        blk_cin = cin;
        blk_p   = 1'b1;
        p       = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            p      = a[i] ^ b[i];
            sum[i] = p ^ c;
            c      = (a[i] & b[i]) | (p & c);
            blk_p  = blk_p & p;
            // Block boundary: take the skip path when the whole block propagates
            if (((i % int'(BS)) == int'(BS) - 1) || (i == int'(N) - 1)) begin
                if (blk_p) c = blk_cin;
                blk_cin = c;
                blk_p   = 1'b1;
            end
        end
        cout = c;
    end
endmodule

module carry_skip_add_arbiter #(
    parameter int unsigned N          = 8,
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned NREQ       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREQ-1:0]                req_valid,
    output logic [NREQ-1:0]                req_ready,
    input  logic [NREQ*N-1:0]              req_a,
    input  logic [NREQ*N-1:0]              req_b,
    input  logic [NREQ-1:0]                req_cin,
    input  logic [NREQ-1:0]                req_chain,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [N-1:0]                   rsp_sum,
    output logic                           rsp_cout
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ARB, LOCK} state_t;

    state_t         state, state_next;
    logic           carry, carry_next;
    logic [IDW-1:0] owner, owner_next;
    logic [IDW-1:0] last_grant, last_grant_next;

    logic           accept;
    logic           found;
    logic [IDW-1:0] gnt;
    logic           xfer;
    int unsigned    search_idx;

    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           op_cin;
    logic           sel_cin;
    logic           sel_chain;
    logic [N-1:0]   add_sum;
    logic           add_cout;

    // Response slot can take a new result when empty or draining this cycle
    assign accept = !rst && (!rsp_valid || rsp_ready);

    // Winner select: owner only while locked, else round-robin after last_grant
    always_comb begin
        found      = 1'b0;
        gnt        = '0;
        search_idx = 0;
        if (state == LOCK) begin
            gnt   = owner;
            found = req_valid[owner];
        end else begin
            for (int k = 1; k <= int'(NREQ); k++) begin
                search_idx = (int'(last_grant) + k) % NREQ;
                if (!found && req_valid[search_idx]) begin
                    found = 1'b1;
                    gnt   = IDW'(search_idx);
                end
            end
        end
    end

    assign xfer = accept && found;

    // Handshake and operand mux for the winner
    always_comb begin
        req_ready = '0;
        op_a      = '0;
        op_b      = '0;
        sel_cin   = 1'b0;
        sel_chain = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (IDW'(i) == gnt) begin
                op_a      = req_a[i*N +: N];
                op_b      = req_b[i*N +: N];
                sel_cin   = req_cin[i];
                sel_chain = req_chain[i];
                req_ready[i] = xfer;
            end
        end
    end

    // A chained beat ignores its own cin and uses the stored carry instead
    assign op_cin = (state == LOCK) ? carry : sel_cin;

    carry_skip_adder #(
        .N          (N),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state logic for the lock FSM and the arbitration pointer
    always_comb begin
        state_next      = state;
        carry_next      = carry;
        owner_next      = owner;
        last_grant_next = last_grant;
        if (xfer) begin
            last_grant_next = gnt;
            case (state)
                ARB: begin
                    if (sel_chain) begin
                        state_next = LOCK;
                        owner_next = gnt;
                        carry_next = add_cout;
                    end
                end
                LOCK: begin
                    if (sel_chain) begin
                        carry_next = add_cout;
                    end else begin
                        state_next = ARB;
                        carry_next = 1'b0;
                    end
                end
                default: state_next = ARB;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            carry      <= 1'b0;
            owner      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            state      <= state_next;
            carry      <= carry_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
        end
    end

    // One-entry response register
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else if (xfer) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_carry_skip_add_arbiter.sv
// Directed self-checking bench for carry_skip_add_arbiter (N=8, NREQ=4, BLOCK_SIZE=4).
module tb_carry_skip_add_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_cin;
    logic [3:0]  req_chain;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_cout;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    carry_skip_add_arbiter #(.N(8), .BLOCK_SIZE(4), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    task automatic set_req(input int i, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic cin, input logic chain);
        req_valid[i]     = v;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_cin[i]       = cin;
        req_chain[i]     = chain;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_reqs();
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== 12'h0) begin
            $display("FAIL reset_rsp got v=%b id=%0d sum=%h c=%b exp all zero",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
        tests++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL reset_ready got %b exp 0000", req_ready);
            fails++;
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b0);
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL single_ready got %b exp 0001", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd0, 8'h80, 1'b0}) begin
            $display("FAIL single_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=0 sum=80 c=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [7:0] exp_sum [4] = '{8'h01, 8'h12, 8'h23, 8'h34};
        logic [3:0] exp_rdy [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        set_req(0, 1'b1, 8'h01, 8'h00, 1'b0, 1'b0);
        set_req(1, 1'b1, 8'h11, 8'h01, 1'b0, 1'b0);
        set_req(2, 1'b1, 8'h21, 8'h02, 1'b0, 1'b0);
        set_req(3, 1'b1, 8'h31, 8'h03, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (req_ready !== exp_rdy[k]) begin
                $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, exp_rdy[k]);
                fails++;
            end
            @(posedge clk);
            #1;
            tests++;
            if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, exp_id[k], exp_sum[exp_id[k]]}) begin
                $display("FAIL rr_rsp[%0d] got v=%b id=%0d sum=%h exp v=1 id=%0d sum=%h",
                         k, rsp_valid, rsp_id, rsp_sum, exp_id[k], exp_sum[exp_id[k]]);
                fails++;
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b1;
        set_req(1, 1'b1, 8'h20, 8'h03, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        clear_reqs();
        rsp_ready = 1'b0;
        set_req(2, 1'b1, 8'h40, 8'h02, 1'b0, 1'b0);
        set_req(3, 1'b1, 8'h50, 8'h05, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000) begin
                $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready);
                fails++;
            end
            @(posedge clk);
            #1;
            tests++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd1, 8'h24, 1'b0}) begin
                $display("FAIL bp_hold[%0d] got v=%b id=%0d sum=%h c=%b exp v=1 id=1 sum=24 c=0",
                         k, rsp_valid, rsp_id, rsp_sum, rsp_cout);
                fails++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL bp_release_ready got %b exp 0100", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd2, 8'h42}) begin
            $display("FAIL bp_release_rsp got v=%b id=%0d sum=%h exp v=1 id=2 sum=42",
                     rsp_valid, rsp_id, rsp_sum);
            fails++;
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_chain();
        // Move the pointer to req1 so req2 is next in line
        set_req(1, 1'b1, 8'h05, 8'h05, 1'b0, 1'b0);
        #1;
        tests++;
        if (req_ready !== 4'b0010) begin
            $display("FAIL chain_pre_ready got %b exp 0010", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_id, rsp_sum} !== {2'd1, 8'h0A}) begin
            $display("FAIL chain_pre_rsp got id=%0d sum=%h exp id=1 sum=0a", rsp_id, rsp_sum);
            fails++;
        end
        @(negedge clk);
        set_req(2, 1'b1, 8'hFF, 8'h01, 1'b1, 1'b1);
        set_req(3, 1'b1, 8'h30, 8'h01, 1'b0, 1'b0);
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL chain_b1_ready got %b exp 0100", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd2, 8'h01, 1'b1}) begin
            $display("FAIL chain_b1_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=2 sum=01 c=1",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
        @(negedge clk);
        // Owner idles for a cycle: everyone else must stay stalled
        req_valid[2] = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL chain_idle_ready got %b exp 0000", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL chain_idle_rsp got v=%b exp 0", rsp_valid);
            fails++;
        end
        @(negedge clk);
        set_req(2, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
        #1;
        tests++;
        if (req_ready !== 4'b0100) begin
            $display("FAIL chain_b2_ready got %b exp 0100", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd2, 8'h01, 1'b0}) begin
            $display("FAIL chain_b2_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=2 sum=01 c=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        tests++;
        if (req_ready !== 4'b1000) begin
            $display("FAIL chain_after_ready got %b exp 1000", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_id, rsp_sum, rsp_cout} !== {2'd3, 8'h31, 1'b0}) begin
            $display("FAIL chain_after_rsp got id=%0d sum=%h c=%b exp id=3 sum=31 c=0",
                     rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_edge_arith();
        logic [7:0] va [3] = '{8'hFF, 8'h00, 8'h80};
        logic [7:0] vb [3] = '{8'hFF, 8'h00, 8'h80};
        logic       vc [3] = '{1'b1, 1'b0, 1'b0};
        logic [8:0] ex [3] = '{9'h1FF, 9'h000, 9'h100};
        for (int k = 0; k < 3; k++) begin
            set_req(0, 1'b1, va[k], vb[k], vc[k], 1'b0);
            @(posedge clk);
            #1;
            tests++;
            if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd0, ex[k]}) begin
                $display("FAIL edge_arith[%0d] got v=%b id=%0d c=%b sum=%h exp v=1 id=0 {c,sum}=%h",
                         k, rsp_valid, rsp_id, rsp_cout, rsp_sum, ex[k]);
                fails++;
            end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    task automatic test_reset_in_lock();
        set_req(1, 1'b1, 8'h10, 8'h10, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 8'h20}) begin
            $display("FAIL lock_setup got v=%b id=%0d sum=%h exp v=1 id=1 sum=20",
                     rsp_valid, rsp_id, rsp_sum);
            fails++;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        rst       = 1'b1;
        set_req(0, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        set_req(2, 1'b1, 8'h22, 8'h22, 1'b0, 1'b0);
        set_req(3, 1'b1, 8'h33, 8'h33, 1'b0, 1'b0);
        #1;
        tests++;
        if (req_ready !== 4'b0000) begin
            $display("FAIL lock_rst_ready got %b exp 0000", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== 12'h0) begin
            $display("FAIL lock_rst_rsp got v=%b id=%0d sum=%h c=%b exp all zero",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
        @(negedge clk);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        tests++;
        if (req_ready !== 4'b0001) begin
            $display("FAIL lock_post_ready got %b exp 0001", req_ready);
            fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_cout} !== {1'b1, 2'd0, 8'h03, 1'b0}) begin
            $display("FAIL lock_post_rsp got v=%b id=%0d sum=%h c=%b exp v=1 id=0 sum=03 c=0",
                     rsp_valid, rsp_id, rsp_sum, rsp_cout);
            fails++;
        end
        @(negedge clk);
        clear_reqs();
    endtask

    initial begin
        rst       = 1'b1;
        rsp_ready = 1'b0;
        clear_reqs();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_chain();
        test_edge_arith();
        test_reset_in_lock();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
